// File: rtl/tdm_demux_1x4_pkg.sv
// rtl/tdm_demux_1x4_pkg.sv - shared constants, state type and lane helper for the TDM link
package tdm_pkg;

   localparam int NCH    = 4;
   localparam int SLOT_W = 2;

   typedef enum logic {HUNT, COLLECT} state_t;

   // Lane k of a packed NCH*w bus starts at bit k*w; the transmit mux uses the same packing.
   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/tdm_demux_1x4_if.sv
// rtl/tdm_demux_1x4_if.sv - serial slot input and demultiplexed lane/frame outputs
interface tdm_demux_1x4_if #(parameter int W = 1);
   import tdm_pkg::*;

   logic [W-1:0]        din;
   logic                din_valid;
   logic                sof;
   logic [SLOT_W-1:0]   slot;
   logic [NCH*W-1:0]    ch_data;
   logic [NCH-1:0]      ch_stb;
   logic [NCH*W-1:0]    frame_data;
   logic                frame_valid;
   logic                frame_err;

   modport master (
      output din, din_valid, sof,
      input  slot, ch_data, ch_stb, frame_data, frame_valid, frame_err
   );

   modport slave (
      input  din, din_valid, sof,
      output slot, ch_data, ch_stb, frame_data, frame_valid, frame_err
   );

endinterface

// File: rtl/tdm_demux_1x4_demux_1x2.sv
// rtl/tdm_demux_1x4_demux_1x2.sv - combinational 1:2 enable demux, leaf of the lane-enable tree
module demux_1x2 (
   input  logic       in,
   input  logic       sel,
   output logic [1:0] y
);

   assign y[0] = in & ~sel;
   assign y[1] = in &  sel;

endmodule

// File: rtl/tdm_demux_1x4.sv
// rtl/tdm_demux_1x4.sv - splits a 4-slot TDM stream into registered lanes and frame snapshots
module tdm_demux_1x4
   import tdm_pkg::*;
#(
   parameter int W = 1
) (
   input  logic             clk,
   input  logic             rst,
   tdm_demux_1x4_if.slave   bus
);

   state_t              state, state_nx;
   logic [SLOT_W-1:0]   slot_q, slot_nx, wr_slot;
   logic                accept, err, done;
   logic [1:0]          root_y;
   logic [NCH-1:0]      we;

   logic [NCH*W-1:0]    ch_data_q, frame_data_q;
   logic [NCH-1:0]      ch_stb_q;
   logic                frame_valid_q, frame_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= HUNT;
         slot_q <= '0;
      end else begin
         state  <= state_nx;
         slot_q <= slot_nx;
      end
   end

   always_comb begin
      state_nx = state;
      if (bus.din_valid) begin
         if (state == HUNT && bus.sof)
            state_nx = COLLECT;
         else if (state == COLLECT && !bus.sof && slot_q == '0)
            state_nx = HUNT;
      end
   end

   // In COLLECT a mid-frame beat is always taken (sof restarts at slot 0); at slot 0 only sof is taken.
   always_comb begin
      accept  = 1'b0;
      err     = 1'b0;
      wr_slot = bus.sof ? '0 : slot_q;
      if (bus.din_valid) begin
         if (state == HUNT) begin
            accept = bus.sof;
         end else begin
            accept = (slot_q != '0) || bus.sof;
            err    = (slot_q != '0) ? bus.sof : !bus.sof;
         end
      end
      done    = accept && (wr_slot == 2'd3);
      slot_nx = accept ? wr_slot + 2'd1 : slot_q;
   end

   demux_1x2 u_root  (.in(accept),    .sel(wr_slot[1]), .y(root_y));
   demux_1x2 u_leaf0 (.in(root_y[0]), .sel(wr_slot[0]), .y(we[1:0]));
   demux_1x2 u_leaf1 (.in(root_y[1]), .sel(wr_slot[0]), .y(we[3:2]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch_data_q     <= '0;
         ch_stb_q      <= '0;
         frame_data_q  <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            if (we[k])
               ch_data_q[lane_lo(k, W) +: W] <= bus.din;
         end
         ch_stb_q      <= we;
         frame_valid_q <= done;
         frame_err_q   <= err;
         // Lanes 0..2 of this frame are already registered when the slot-3 beat arrives.
         if (done)
            frame_data_q <= {bus.din, ch_data_q[lane_lo(NCH-1, W)-1:0]};
      end
   end

   assign bus.slot        = slot_q;
   assign bus.ch_data     = ch_data_q;
   assign bus.ch_stb      = ch_stb_q;
   assign bus.frame_data  = frame_data_q;
   assign bus.frame_valid = frame_valid_q;
   assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb/tb_tdm_demux_1x4.sv - scoreboard bench for tdm_demux_1x4 with directed frames
module tb_tdm_demux_1x4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int          cyc;
      logic [3:0]  stb;
      logic        fv;
      logic        fe;
      logic [7:0]  lane;
      logic [31:0] frame;
   } exp_t;

   exp_t q[$];

   tdm_demux_1x4_if #(.W(8)) bus ();

   tdm_demux_1x4 #(.W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic beat(input logic [7:0] d, input logic s, input logic [3:0] stb,
                       input logic fv, input logic fe, input logic [31:0] fr);
      @(posedge clk);
      #1;
      if (stb != 4'b0 || fv || fe)
         q.push_back('{cyc + 1, stb, fv, fe, d, fr});
      bus.din       = d;
      bus.sof       = s;
      bus.din_valid = 1'b1;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      bus.din_valid = 1'b0;
      bus.sof       = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_slot"},  bus.slot, 0);
      chk({tag, "_data"},  bus.ch_data, 0);
      chk({tag, "_stb"},   bus.ch_stb, 0);
      chk({tag, "_frame"}, bus.frame_data, 0);
      chk({tag, "_fv"},    bus.frame_valid, 0);
      chk({tag, "_fe"},    bus.frame_err, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && (bus.ch_stb != 4'b0 || bus.frame_valid || bus.frame_err)) begin
         if (q.size() == 0) begin
            chk("unexpected_event", {bus.ch_stb, bus.frame_valid, bus.frame_err}, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("event_cycle", cyc, e.cyc);
            chk("ch_stb", bus.ch_stb, e.stb);
            chk("frame_valid", bus.frame_valid, e.fv);
            chk("frame_err", bus.frame_err, e.fe);
            for (int k = 0; k < 4; k++)
               if (e.stb[k])
                  chk("lane_data", bus.ch_data[k*8 +: 8], e.lane);
            if (e.fv)
               chk("frame_data", bus.frame_data, e.frame);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.din       = '0;
      bus.sof       = 1'b0;
      bus.din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst = 1'b0;

      // HUNT discards non-sof beats, then a clean frame
      beat(8'hAA, 0, 4'b0000, 0, 0, 0);
      beat(8'hBB, 0, 4'b0000, 0, 0, 0);
      beat(8'h01, 1, 4'b0001, 0, 0, 0);
      beat(8'h02, 0, 4'b0010, 0, 0, 0);
      beat(8'h03, 0, 4'b0100, 0, 0, 0);
      beat(8'h04, 0, 4'b1000, 1, 0, 32'h04030201);

      // back-to-back normal frame
      beat(8'h11, 1, 4'b0001, 0, 0, 0);
      beat(8'h22, 0, 4'b0010, 0, 0, 0);
      beat(8'h33, 0, 4'b0100, 0, 0, 0);
      beat(8'h44, 0, 4'b1000, 1, 0, 32'h44332211);

      // early sof drops the partial frame
      beat(8'h10, 1, 4'b0001, 0, 0, 0);
      beat(8'h20, 0, 4'b0010, 0, 0, 0);
      beat(8'h30, 1, 4'b0001, 0, 1, 0);
      beat(8'h40, 0, 4'b0010, 0, 0, 0);
      beat(8'h50, 0, 4'b0100, 0, 0, 0);
      beat(8'h60, 0, 4'b1000, 1, 0, 32'h60504030);

      // missing sof after a complete frame
      beat(8'h01, 1, 4'b0001, 0, 0, 0);
      beat(8'h02, 0, 4'b0010, 0, 0, 0);
      beat(8'h03, 0, 4'b0100, 0, 0, 0);
      beat(8'h04, 0, 4'b1000, 1, 0, 32'h04030201);
      beat(8'h05, 0, 4'b0000, 0, 1, 0);
      beat(8'h06, 1, 4'b0001, 0, 0, 0);
      beat(8'h07, 0, 4'b0010, 0, 0, 0);
      beat(8'h08, 0, 4'b0100, 0, 0, 0);
      beat(8'h09, 0, 4'b1000, 1, 0, 32'h09080706);

      // gaps between beats
      beat(8'hA1, 1, 4'b0001, 0, 0, 0);
      idle();
      chk("gap_slot1", bus.slot, 1);
      idle();
      chk("gap_slot1_hold", bus.slot, 1);
      chk("gap_stb_clear", bus.ch_stb, 0);
      chk("gap_lane0_hold", bus.ch_data[7:0], 8'hA1);
      beat(8'hA2, 0, 4'b0010, 0, 0, 0);
      idle();
      idle();
      chk("gap_slot2", bus.slot, 2);
      beat(8'hA3, 0, 4'b0100, 0, 0, 0);
      idle();
      beat(8'hA4, 0, 4'b1000, 1, 0, 32'hA4A3A2A1);
      idle();
      idle();
      chk("gap_fv_clear", bus.frame_valid, 0);
      chk("gap_frame_hold", bus.frame_data, 32'hA4A3A2A1);

      // asynchronous reset mid-frame
      beat(8'hB1, 1, 4'b0001, 0, 0, 0);
      beat(8'hB2, 0, 4'b0010, 0, 0, 0);
      idle();
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      beat(8'hC1, 0, 4'b0000, 0, 0, 0);
      idle();
      chk("post_rst_slot", bus.slot, 0);
      chk("post_rst_data", bus.ch_data, 0);

      repeat (4) idle();
      chk("pending_events", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
